// File: rtl/flash_rd_seq.sv
// flash_rd_seq: on request, walks flash addresses 0..7 under CE0, samples the
// single-bit DOUT at each address and presents the assembled byte.
// An OCD stop (SVSTOP) during the walk aborts it without touching rd_data.
module flash_rd_seq #(
  parameter int WAIT_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_res_n,
  input  logic       req,
  input  logic       SVSTOP,
  input  logic       DOUT,
  output logic       cibc_ce0,
  output logic [2:0] addr,
  output logic       busy,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rd_abort
);

  // state  | meaning
  // IDLE   | waiting for req; CE0 low, addr holds last value
  // SETUP  | CE0 low, addr stable for one cycle before the access window
  // ACCESS | CE0 high for WAIT_CYC+1 cycles; DOUT sampled on the last one
  // DONE   | byte published, rd_valid high for one cycle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [7:0] shadow_q, shadow_d;
  logic       ce0_d;
  logic [2:0] addr_d;
  logic       busy_d;
  logic [7:0] rd_data_d;
  logic       valid_d;
  logic       abort_d;

  // State and output registers; every output is a flop.
  always_ff @(posedge clk) begin
    if (!rst_res_n) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      wcnt_q   <= 4'd0;
      shadow_q <= 8'h00;
      cibc_ce0 <= 1'b0;
      addr     <= 3'd0;
      busy     <= 1'b0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      rd_abort <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      shadow_q <= shadow_d;
      cibc_ce0 <= ce0_d;
      addr     <= addr_d;
      busy     <= busy_d;
      rd_data  <= rd_data_d;
      rd_valid <= valid_d;
      rd_abort <= abort_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    shadow_d  = shadow_q;
    ce0_d     = 1'b0;
    addr_d    = addr;
    rd_data_d = rd_data;
    valid_d   = 1'b0;
    abort_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req && !SVSTOP) begin
          idx_d    = 3'd0;
          addr_d   = 3'd0;
          shadow_d = 8'h00;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (SVSTOP) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d  = WAIT_LD;
          ce0_d   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (SVSTOP) begin
          // shadow is simply abandoned; rd_data keeps the last good byte
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
          ce0_d  = 1'b1;
        end else begin
          shadow_d[idx_q] = DOUT;
          if (idx_q == 3'd7) begin
            rd_data_d = shadow_d;
            valid_d   = 1'b1;
            state_d   = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            addr_d  = idx_q + 3'd1;
            state_d = SETUP;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
